clock_period_meter: RTL
=======================

// Module: clock_period_meter
// PURPOSE
//  Downstream consumer of the divided clock (frequency_divider_by2 out_clk or any slower divider output).
//  Samples in_clk as data in the clk domain and measures its period and high time in clk cycles.
//  Flags lock once the period is stable and flags a stalled input.
//  Used as the on-chip check that a divider stage produces the intended ratio and duty cycle.
// PARAMETERS
//  CNT_W        16  width of the elapsed counter and of the period/high_time outputs
//  SYNC_STAGES  2   synchronizer flops on in_clk (>=1; set to 1 only when in_clk is generated from clk)
//  LOCK_COUNT   4   consecutive identical periods required to assert locked (>=2)
// PORTS
//  clk         in   1      system clock; all logic on posedge
//  rst         in   1      synchronous, active-high reset
//  in_clk      in   1      divided clock under measurement, treated as an asynchronous data input
//  enable      in   1      measurement enable; low = idle
//  period      out  CNT_W  last measured rise-to-rise interval in clk cycles
//  high_time   out  CNT_W  last measured rise-to-fall interval in clk cycles
//  meas_valid  out  1      one-cycle pulse when period/high_time update
//  locked      out  1      LOCK_COUNT consecutive equal periods measured
//  overflow    out  1      sticky; elapsed counter saturated without an edge
// BEHAVIOUR
//  Reset: period=0, high_time=0, meas_valid=0, locked=0, overflow=0; sync flops=0; FSM=IDLE; elapsed e=0.
//  in_clk passes through SYNC_STAGES flops to give s. One more flop gives s_d.
//  rise = s & ~s_d; fall = ~s & s_d. Edge-to-detect latency is SYNC_STAGES+1 clk cycles.
//  FSM states and transitions:
//   IDLE -> WAIT_RISE when enable=1.
//   WAIT_RISE: falls are ignored. On rise: e<=1, go to MEAS_HIGH. No meas_valid on this first rise.
//   MEAS_HIGH: on fall: hcap<=e, e<=e+1, go to MEAS_LOW.
//   MEAS_LOW: on rise: period<=e, high_time<=hcap, meas_valid<=1, e<=1, go to MEAS_HIGH.
//   All other cycles in MEAS_*: e<=e+1.
//  Outputs are registered; meas_valid is high for exactly the cycle after the rise-detect cycle.
//  Divide-by-2 input (toggling every clk) measures as period=2, high_time=1.
//  Lock: on each valid, compare the new period with the previous one.
//   Equal: match_cnt++ (saturating). Different: match_cnt<=1.
//   locked = (match_cnt >= LOCK_COUNT); it updates in the same cycle as meas_valid.
//  Overflow: if e reaches 2^CNT_W-1 in MEAS_HIGH or MEAS_LOW:
//   overflow<=1, locked<=0, match_cnt<=0, go to WAIT_RISE.
//   period and high_time hold their values; no meas_valid.
//   overflow clears on the next meas_valid or on rst.
//  enable low in any state: go to IDLE next cycle, and the measurement in progress is discarded.
//   meas_valid<=0, locked<=0, match_cnt<=0; period, high_time and overflow hold.
//  rst mid-measurement: everything returns to reset values. The first valid needs two fresh rises.
//  Simultaneous rise and overflow in the same cycle: the rise wins (measurement valid, overflow unchanged).
//  All counter arithmetic is unsigned CNT_W bits and e never wraps. period is always >=2 and high_time >=1.
// STRUCTURE
//  Shared package/include clock_meter_pkg: FSM state localparams IDLE=2'd0, WAIT_RISE=2'd1,
//   MEAS_HIGH=2'd2, MEAS_LOW=2'd3.
//  Sub-module sync_edge_detect (params SYNC_STAGES; ports clk, rst, d, level, rise, fall)
//   holds the synchronizer and edge detect.
//  Top level holds the FSM, elapsed counter, capture registers and lock logic.
// TESTING (clk period 20; bench drives in_clk on negedge clk; SYNC_STAGES=2)
//  1. in_clk = frequency_divider_by2 out_clk, enable=1:
//     each valid gives period=2, high_time=1; locked=1 on the 4th valid; overflow stays 0.
//  2. in_clk high 3 / low 7 cycles: period=10, high_time=3;
//     first meas_valid appears after the 2nd rise + 3 cycles.
//  3. CNT_W=8, in_clk stuck high after one rise: overflow=1 when e=255, locked=0, no meas_valid;
//     resumed period 6 clears overflow on the next valid.
//  4. Locked at period 10, switch to period 12: locked=0 on the first 12 valid;
//     locked=1 again on the 4th consecutive 12.
//  5. rst pulsed for 1 cycle during MEAS_HIGH: all outputs 0 next cycle;
//     no valid until two further rises are seen.
//  6. enable=0 for 20 cycles mid-run: meas_valid never pulses, locked=0, period holds;
//     after enable=1 the first valid needs two rises.

Source files
------------

// File: rtl/clock_meter_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding and
// small helpers used to size internal counters.
package clock_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } meter_state_e;

  // Bits needed to hold a match counter that saturates at lock_count.
  function automatic int unsigned match_cnt_width(input int unsigned lock_count);
    return (lock_count < 2) ? 1 : $clog2(lock_count + 1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into the clk domain and produces
// single-cycle rise/fall strobes from the synchronized level.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;

  // Synchronizer chain plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
    end else begin
      r_sync[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_level_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = level & ~r_level_d;
  assign fall  = ~level & r_level_d;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slower clock sampled as data in the
// clk domain, flags lock after LOCK_COUNT equal periods, and flags a
// stalled input via a sticky overflow bit.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_clk,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             overflow
);

  localparam int unsigned         MATCH_W   = match_cnt_width(LOCK_COUNT);
  localparam logic [CNT_W-1:0]    E_MAX     = '1;
  localparam logic [CNT_W-1:0]    E_ONE     = CNT_W'(1);
  localparam logic [MATCH_W-1:0]  MATCH_SAT = MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0]  MATCH_ONE = MATCH_W'(1);

  meter_state_e       r_state;
  logic [CNT_W-1:0]   r_e;
  logic [CNT_W-1:0]   r_hcap;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_high_time;
  logic               r_meas_valid;
  logic               r_locked;
  logic               r_overflow;
  logic [MATCH_W-1:0] r_match;

  logic               w_level_unused;
  logic               w_rise;
  logic               w_fall;
  logic [MATCH_W-1:0] w_match_next;

  // The FSM works purely on edge strobes; the synchronized level is not needed here.
  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk   (clk),
    .rst   (rst),
    .d     (in_clk),
    .level (w_level_unused),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  // Next match count if the current elapsed count is accepted as a new period.
  always_comb begin
    w_match_next = MATCH_ONE;
    if (r_e == r_period) begin
      w_match_next = (r_match == MATCH_SAT) ? r_match : r_match + MATCH_ONE;
    end
  end

  // Measurement FSM, elapsed counter, capture registers and lock tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_e          <= '0;
      r_hcap       <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_overflow   <= 1'b0;
      r_match      <= '0;
    end else begin
      r_meas_valid <= 1'b0;
      if (!enable) begin
        r_state  <= IDLE;
        r_e      <= '0;
        r_locked <= 1'b0;
        r_match  <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_state <= WAIT_RISE;
          end
          WAIT_RISE: begin
            if (w_rise) begin
              r_e     <= E_ONE;
              r_state <= MEAS_HIGH;
            end
          end
          MEAS_HIGH: begin
            // Saturation is checked before the fall so e can never wrap.
            if (r_e == E_MAX) begin
              r_overflow <= 1'b1;
              r_locked   <= 1'b0;
              r_match    <= '0;
              r_e        <= '0;
              r_state    <= WAIT_RISE;
            end else if (w_fall) begin
              r_hcap  <= r_e;
              r_e     <= r_e + E_ONE;
              r_state <= MEAS_LOW;
            end else begin
              r_e <= r_e + E_ONE;
            end
          end
          MEAS_LOW: begin
            // A rise coinciding with saturation still completes the measurement.
            if (w_rise) begin
              r_period     <= r_e;
              r_high_time  <= r_hcap;
              r_meas_valid <= 1'b1;
              r_overflow   <= 1'b0;
              r_match      <= w_match_next;
              r_locked     <= (w_match_next >= MATCH_SAT);
              r_e          <= E_ONE;
              r_state      <= MEAS_HIGH;
            end else if (r_e == E_MAX) begin
              r_overflow <= 1'b1;
              r_locked   <= 1'b0;
              r_match    <= '0;
              r_e        <= '0;
              r_state    <= WAIT_RISE;
            end else begin
              r_e <= r_e + E_ONE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign period     = r_period;
  assign high_time  = r_high_time;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign overflow   = r_overflow;

endmodule
